// File: rtl/seq_pkg.sv
// Shared types for the instruction sequencer: opcodes, FSM states,
// one-hot ALU selects, comparator flag encodings and the decoded control bundle.
package seq_pkg;

    localparam int unsigned IR_W   = 18;
    localparam int unsigned ADDR_W = 18;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_AND  = 4'h1,
        OP_NAND = 4'h2,
        OP_NOR  = 4'h3,
        OP_ADDI = 4'h4,
        OP_ANDI = 4'h5,
        OP_LD   = 4'h6,
        OP_ST   = 4'h7,
        OP_CMP  = 4'h8,
        OP_JUMP = 4'h9,
        OP_JE   = 4'hA,
        OP_JA   = 4'hB,
        OP_JB   = 4'hC,
        OP_JAE  = 4'hD,
        OP_JBE  = 4'hE,
        OP_ILL  = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_NAND = 4'b0100;
    localparam logic [3:0] ALU_NOR  = 4'b1000;

    localparam logic [2:0] CMP_NONE = 3'b000;
    localparam logic [2:0] CMP_GT   = 3'b100;
    localparam logic [2:0] CMP_EQ   = 3'b010;
    localparam logic [2:0] CMP_LT   = 3'b001;

    typedef struct packed {
        opcode_t           op;
        logic [3:0]        alu_select;
        logic              imm_sel;
        logic [3:0]        dst;
        logic [3:0]        src1;
        logic [3:0]        src2;
        logic [ADDR_W-1:0] mem_addr;
        logic              is_alu;
        logic              is_cmp;
        logic              is_jump;
        logic              is_ld;
        logic              is_st;
        logic              illegal;
    } ctrl_t;

    function automatic logic jump_taken(input opcode_t op, input logic [2:0] flags);
        logic gt, eq, lt;
        gt = (flags & CMP_GT) != '0;
        eq = (flags & CMP_EQ) != '0;
        lt = (flags & CMP_LT) != '0;
        case (op)
            OP_JUMP: jump_taken = 1'b1;
            OP_JE:   jump_taken = eq;
            OP_JA:   jump_taken = gt;
            OP_JB:   jump_taken = lt;
            OP_JAE:  jump_taken = gt | eq;
            OP_JBE:  jump_taken = lt | eq;
            default: jump_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational IR decode: splits the instruction word into register
// fields, jump/memory address and per-class control flags.
module instr_decoder
    import seq_pkg::*;
(
    input  logic [IR_W-1:0] ir,
    output ctrl_t           ctrl
);

    always_comb begin
        ctrl          = '0;
        ctrl.op       = opcode_t'(ir[17:14]);
        ctrl.dst      = ir[13:10];
        ctrl.src1     = ir[9:6];
        ctrl.src2     = ir[3:0];
        ctrl.mem_addr = {{(ADDR_W-10){1'b0}}, ir[9:0]};
        case (ctrl.op)
            OP_ADD:  begin ctrl.is_alu = 1'b1; ctrl.alu_select = ALU_ADD;  end
            OP_AND:  begin ctrl.is_alu = 1'b1; ctrl.alu_select = ALU_AND;  end
            OP_NAND: begin ctrl.is_alu = 1'b1; ctrl.alu_select = ALU_NAND; end
            OP_NOR:  begin ctrl.is_alu = 1'b1; ctrl.alu_select = ALU_NOR;  end
            OP_ADDI: begin ctrl.is_alu = 1'b1; ctrl.alu_select = ALU_ADD; ctrl.imm_sel = 1'b1; end
            OP_ANDI: begin ctrl.is_alu = 1'b1; ctrl.alu_select = ALU_AND; ctrl.imm_sel = 1'b1; end
            OP_LD:   ctrl.is_ld   = 1'b1;
            OP_ST:   ctrl.is_st   = 1'b1;
            OP_CMP:  ctrl.is_cmp  = 1'b1;
            OP_JUMP, OP_JE, OP_JA, OP_JB, OP_JAE, OP_JBE:
                     ctrl.is_jump = 1'b1;
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FSM, instruction register, compare flags.
// Define SEQ_MEM_TIMEOUT_EN to add the fetch/data-ack watchdog (WDOG_CYCLES).
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned WDOG_CYCLES = 16
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [IR_W-1:0]   imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [2:0]        cmp_in,
    output logic [3:0]        alu_select,
    output logic              imm_sel,
    output logic              wb_sel,
    output logic [3:0]        r1_addr,
    output logic [3:0]        r2_addr,
    output logic [3:0]        w_addr,
    output logic              regw_enable,
    output logic              pc_inc,
    output logic              pc_wrt,
    output logic              busy,
    output logic              fault
);

    state_t          state_q, state_n;
    logic [IR_W-1:0] ir_q;
    logic [2:0]      flags_q;
    logic            fault_q;
    logic            ir_load, flags_load, fault_set;
    ctrl_t           ctrl;

    if (WDOG_CYCLES < 1) begin : g_wdog_range
        $error("WDOG_CYCLES must be at least 1");
    end

    instr_decoder u_decoder (
        .ir   (ir_q),
        .ctrl (ctrl)
    );

`ifdef SEQ_MEM_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_q;
    logic              wdog_run, wdog_expired;

    // Counts consecutive un-acked request cycles; any ack or state change clears it.
    assign wdog_run     = (state_q == S_FETCH && !imem_ack) || (state_q == S_MEM && !dmem_ack);
    assign wdog_expired = wdog_run && (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || !wdog_run) wdog_q <= '0;
        else                    wdog_q <= wdog_q + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            flags_q <= CMP_NONE;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_n;
            if (ir_load)    ir_q    <= imem_rdata;
            if (flags_load) flags_q <= cmp_in;
            if (fault_set)  fault_q <= 1'b1;
        end
    end

    assign busy  = (state_q != S_IDLE) && (state_q != S_HALT);
    assign fault = fault_q;

    always_comb begin
        state_n     = state_q;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        mem_addr    = '0;
        alu_select  = ALU_NONE;
        imm_sel     = 1'b0;
        wb_sel      = 1'b0;
        r1_addr     = '0;
        r2_addr     = '0;
        w_addr      = '0;
        regw_enable = 1'b0;
        pc_inc      = 1'b0;
        pc_wrt      = 1'b0;
        ir_load     = 1'b0;
        flags_load  = 1'b0;
        fault_set   = 1'b0;

        // Decoded fields stay on the bus from EXEC through WB so the datapath sees
        // a stable operand/address set for the whole instruction.
        if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
            r1_addr    = ctrl.is_st ? ctrl.dst : ctrl.src1;
            r2_addr    = ctrl.src2;
            w_addr     = ctrl.dst;
            alu_select = ctrl.alu_select;
            imm_sel    = ctrl.imm_sel;
            mem_addr   = ctrl.mem_addr;
        end

        unique case (state_q)
            S_IDLE: if (start) state_n = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_n = S_DECODE;
                end
`ifdef SEQ_MEM_TIMEOUT_EN
                else if (wdog_expired) begin
                    fault_set = 1'b1;
                    state_n   = S_HALT;
                end
`endif
            end
            S_DECODE: begin
                if (ctrl.illegal) begin
                    fault_set = 1'b1;
                    state_n   = S_HALT;
                end else begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                if (ctrl.is_alu) begin
                    state_n = S_WB;
                end else if (ctrl.is_cmp) begin
                    flags_load = 1'b1;
                    pc_inc     = 1'b1;
                    state_n    = S_FETCH;
                end else if (ctrl.is_jump) begin
                    pc_wrt  = jump_taken(ctrl.op, flags_q);
                    pc_inc  = !pc_wrt;
                    state_n = S_FETCH;
                end else begin
                    state_n = S_MEM;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = ctrl.is_st;
                if (dmem_ack) begin
                    if (ctrl.is_st) begin
                        pc_inc  = 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        state_n = S_WB;
                    end
                end
`ifdef SEQ_MEM_TIMEOUT_EN
                else if (wdog_expired) begin
                    fault_set = 1'b1;
                    state_n   = S_HALT;
                end
`endif
            end
            S_WB: begin
                regw_enable = 1'b1;
                wb_sel      = ctrl.is_ld;
                pc_inc      = 1'b1;
                state_n     = S_FETCH;
            end
            S_HALT: state_n = S_HALT;
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have one parameter: WDOG_CYCLES, default 16, memory-ack watchdog limit (used only with SEQ_MEM_TIMEOUT_EN).
REQ-002 The block SHALL have these ports:
  clk  in  1  rising-edge clock
  reset  in  1  reset, synchronous, active-high
  start  in  1  leave IDLE, begin fetching
  imem_req  out  1  instruction fetch request
  imem_ack  in  1  instruction valid this cycle
  imem_rdata  in  18  fetched instruction
  dmem_req  out  1  data access request
  dmem_we  out  1  1 = store, 0 = load
  dmem_ack  in  1  data access complete
  mem_addr  out  18  zero-extended IR[9:0] for LD/ST/jump target
  cmp_in  in  3  comparator result: 100 gt, 010 eq, 001 lt
  alu_select  out  4  one-hot: 0001 add, 0010 and, 0100 nand, 1000 nor
  imm_sel  out  1  ALU operand b = sign-extended IR[5:0]
  wb_sel  out  1  write-back source: 0 = ALU, 1 = memory
  r1_addr / r2_addr / w_addr  out  4 each  register file addresses
  regw_enable  out  1  register write strobe
  pc_inc  out  1  PC += 1 strobe
  pc_wrt  out  1  PC <= mem_addr strobe
  busy  out  1  not in IDLE or HALT
  fault  out  1  illegal opcode or watchdog expiry (sticky)

Function
REQ-003 IR fields SHALL be: opcode [17:14], dst [13:10], src1 [9:6], src2 [3:0], imm [5:0], addr [9:0].
REQ-004 Opcodes SHALL be: 0-3 ADD/AND/NAND/NOR, 4 ADDI, 5 ANDI, 6 LD, 7 ST, 8 CMP, 9 JUMP, A JE, B JA, C JB, D JAE, E JBE, F illegal.
REQ-005 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-006 IDLE→FETCH when start=1; start SHALL be ignored in other states.
REQ-007 FETCH: imem_req=1 until imem_ack; on the ack cycle IR <= imem_rdata, next state DECODE.
REQ-008 DECODE: one cycle; opcode F → HALT with fault=1; otherwise → EXEC.
REQ-009 EXEC: r1_addr=src1, r2_addr=src2, w_addr=dst, alu_select and imm_sel driven from opcode; ADDI uses 0001, ANDI uses 0010.
REQ-010 ALU ops → WB; WB asserts regw_enable=1, wb_sel=0 and pc_inc=1 for exactly one cycle, then → FETCH.
REQ-011 CMP: EXEC latches cmp_in into internal flags, asserts pc_inc, → FETCH; no register write.
REQ-012 Jumps: EXEC evaluates against latched flags (JE eq; JA gt; JB lt; JAE gt|eq; JBE lt|eq; JUMP always); taken → pc_wrt=1, else pc_inc=1; → FETCH.
REQ-013 LD: EXEC → MEM; MEM holds dmem_req=1, dmem_we=0, mem_addr stable until dmem_ack; → WB with wb_sel=1.
REQ-014 ST: r1_addr=dst (store data); MEM holds dmem_req=1, dmem_we=1; on ack asserts pc_inc, → FETCH.
REQ-015 pc_inc and pc_wrt SHALL never be asserted together; each SHALL be a single-cycle pulse per instruction.
REQ-016 Latency excluding memory wait: ALU/ADDI/ANDI 3 cycles after fetch ack, CMP/jump 2, LD 4, ST 3.
REQ-017 Flags SHALL reset to 000 and change only on CMP; jumps before any CMP are not taken, except JUMP.
REQ-018 HALT SHALL be left only by reset.

Reset
REQ-019 reset SHALL override all other inputs in any state, including mid-MEM or mid-FETCH, and take effect on the next rising edge.
REQ-020 After reset: state IDLE, IR 0, flags 000, fault 0, and every output 0.

Configuration
REQ-021 With SEQ_MEM_TIMEOUT_EN defined, a counter SHALL run in FETCH and MEM; after WDOG_CYCLES cycles with no ack, fault=1, all requests drop, → HALT.
REQ-022 Without SEQ_MEM_TIMEOUT_EN, the block SHALL wait indefinitely for acks and have no counter logic.

Structure
REQ-023 Package seq_pkg SHALL hold the opcode enum, state enum, one-hot ALU select constants and cmp flag encodings.
REQ-024 The block SHALL contain one combinational sub-module, instr_decoder, which maps IR to the control bundle; instr_sequencer holds the FSM, IR, flags and watchdog.

Verification
REQ-025 After reset: start=1, fetch 0x0_2_1_? ADD (dst=2, src1=1, src2=3), ack after 2 cycles → exactly one regw_enable with w_addr=2, alu_select=0001, pc_inc 3 cycles after ack.
REQ-026 CMP with cmp_in=010, then JE addr=0x05A → pc_wrt=1 with mem_addr=0x0005A; JA in the same case → pc_inc only.
REQ-027 LD addr=0x100 with dmem_ack delayed 5 cycles → dmem_req held 6 cycles with dmem_we=0 and mem_addr stable, then regw_enable with wb_sel=1.
REQ-028 Opcode 0xF → HALT, fault=1, busy=0; start ignored; reset → IDLE with fault=0.
REQ-029 reset asserted during MEM of ST → next cycle dmem_req=0, state IDLE, no pc_inc.
REQ-030 With SEQ_MEM_TIMEOUT_EN and imem_ack tied 0 → fault=1 after 16 FETCH cycles, imem_req=0.
